// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes an 8-nibble BCD/hex bus onto an 8-digit
// common-anode 7-segment display. One coherent snapshot of the bus and its
// masks is latched per frame; adds decimal points, leading-zero blanking,
// per-digit blinking and an anti-ghosting dark interval at each slot start.
module seg7_scan_driver #(
    parameter int DIV          = 1000,
    parameter int BLANK        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_bcd,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blink_mask,
    input  logic        lzb,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int PW = $clog2(DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    // Active-low {g,f,e,d,c,b,a} glyphs, hex digits A-F included.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_decode = 7'h40;
            4'h1:    hex_decode = 7'h79;
            4'h2:    hex_decode = 7'h24;
            4'h3:    hex_decode = 7'h30;
            4'h4:    hex_decode = 7'h19;
            4'h5:    hex_decode = 7'h12;
            4'h6:    hex_decode = 7'h02;
            4'h7:    hex_decode = 7'h78;
            4'h8:    hex_decode = 7'h00;
            4'h9:    hex_decode = 7'h10;
            4'hA:    hex_decode = 7'h08;
            4'hB:    hex_decode = 7'h03;
            4'hC:    hex_decode = 7'h46;
            4'hD:    hex_decode = 7'h21;
            4'hE:    hex_decode = 7'h06;
            4'hF:    hex_decode = 7'h0E;
            default: hex_decode = 7'h7F;
        endcase
    endfunction

    logic [PW-1:0] pre_r, pre_nxt_s;
    logic [2:0]    idx_r, idx_nxt_s;
    logic [31:0]   shadow_r;
    logic [7:0]    dp_r, blink_r;
    logic          lzb_r;
    logic [FW-1:0] fcnt_r, fcnt_nxt_s;
    logic          ph_r, ph_nxt_s;
    logic          first_r;

    logic          snap_s;
    logic          in_blank_s;
    logic [31:0]   cur_data_s;
    logic [7:0]    cur_dp_s, cur_blink_s;
    logic          cur_lzb_s;
    logic          upper_nz_s;
    logic          dark_s;
    logic [3:0]    nib_s;
    logic [7:0]    an_nxt_s, seg_nxt_s;

    // The first BLANK cycles of each slot are dark; no window when BLANK is 0.
    generate
        if (BLANK > 0) begin : g_blank
            localparam logic [PW-1:0] BLANK_V = PW'(BLANK);
            assign in_blank_s = (pre_r < BLANK_V);
        end else begin : g_no_blank
            assign in_blank_s = 1'b0;
        end
    endgenerate

    // Next-state for counters and blink phase, and the decoded next outputs.
    always_comb begin
        snap_s     = (pre_r == {PW{1'b0}}) && (idx_r == 3'd0);
        pre_nxt_s  = pre_r + PW'(1);
        idx_nxt_s  = idx_r;
        fcnt_nxt_s = fcnt_r;
        ph_nxt_s   = ph_r;
        if (pre_r == PRE_LAST) begin
            pre_nxt_s = {PW{1'b0}};
            idx_nxt_s = idx_r + 3'd1;
        end else begin
            idx_nxt_s = idx_r;
        end
        // The very first snapshot after reset does not advance the frame count.
        if (snap_s && !first_r) begin
            if (fcnt_r == FCNT_LAST) begin
                fcnt_nxt_s = {FW{1'b0}};
                ph_nxt_s   = ~ph_r;
            end else begin
                fcnt_nxt_s = fcnt_r + FW'(1);
            end
        end else begin
            fcnt_nxt_s = fcnt_r;
        end
        // On the snapshot edge decode straight from the values being latched.
        if (snap_s) begin
            cur_data_s  = data_bcd;
            cur_dp_s    = dp_mask;
            cur_blink_s = blink_mask;
            cur_lzb_s   = lzb;
        end else begin
            cur_data_s  = shadow_r;
            cur_dp_s    = dp_r;
            cur_blink_s = blink_r;
            cur_lzb_s   = lzb_r;
        end
        // Any non-zero nibble at or left of the current digit keeps it lit.
        upper_nz_s = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((k >= int'(idx_r)) && (cur_data_s[4*k +: 4] != 4'h0)) begin
                upper_nz_s = 1'b1;
            end else begin
                upper_nz_s = upper_nz_s;
            end
        end
        nib_s  = cur_data_s[{idx_r, 2'b00} +: 4];
        dark_s = in_blank_s
              || (cur_lzb_s && (idx_r != 3'd0) && !upper_nz_s)
              || (cur_blink_s[idx_r] && !ph_nxt_s);
        if (dark_s) begin
            an_nxt_s  = 8'hFF;
            seg_nxt_s = 8'hFF;
        end else begin
            an_nxt_s  = ~(8'd1 << idx_r);
            seg_nxt_s = {~cur_dp_s[idx_r], hex_decode(nib_s)};
        end
    end

    // Slot prescaler and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= {PW{1'b0}};
            idx_r <= 3'd0;
        end else begin
            pre_r <= pre_nxt_s;
            idx_r <= idx_nxt_s;
        end
    end

    // Per-frame snapshot of the data bus and masks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= 32'h0000_0000;
            dp_r     <= 8'h00;
            blink_r  <= 8'h00;
            lzb_r    <= 1'b0;
        end else if (snap_s) begin
            shadow_r <= data_bcd;
            dp_r     <= dp_mask;
            blink_r  <= blink_mask;
            lzb_r    <= lzb;
        end
    end

    // Frame counter and blink phase (ph = 1 means visible).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_r  <= {FW{1'b0}};
            ph_r    <= 1'b1;
            first_r <= 1'b1;
        end else begin
            fcnt_r  <= fcnt_nxt_s;
            ph_r    <= ph_nxt_s;
            first_r <= first_r && !snap_s;
        end
    end

    // Registered display outputs and frame marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= 8'hFF;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt_s;
            seg         <= seg_nxt_s;
            frame_start <= snap_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a frame-level reference model.
module tb_seg7_scan_driver;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int BF    = 2;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_bcd = 32'h0;
    logic [7:0]  dp_mask = 8'h00;
    logic [7:0]  blink_mask = 8'h00;
    logic        lzb = 1'b0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    int total = 0;
    int bad = 0;
    int n = 0;

    logic [31:0] s_data;
    logic [7:0]  s_dp, s_blink;
    logic        s_lzb;
    logic [7:0]  exp_an, exp_seg;
    logic        exp_fs;
    int          cur_slot, cur_w, cur_fr;
    logic [6:0]  glyph [16];

    seg7_scan_driver #(.DIV(DIV), .BLANK(BLANK), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .data_bcd(data_bcd), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .lzb(lzb), .an(an), .seg(seg),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Advance one edge; the model derives the expected outputs from the edge
    // number since reset release and the inputs seen at each frame start.
    task automatic tick();
        bit dark;
        logic [3:0] nib;
        @(posedge clk);
        if (n % FRAME == 0) begin
            s_data = data_bcd; s_dp = dp_mask; s_blink = blink_mask; s_lzb = lzb;
        end
        cur_slot = (n / DIV) % 8;
        cur_w    = n % DIV;
        cur_fr   = n / FRAME;
        dark = (cur_w < BLANK)
            || (s_lzb && cur_slot != 0 && (s_data >> (4 * cur_slot)) == 32'd0)
            || (s_blink[cur_slot] && ((cur_fr / BF) % 2 == 1));
        nib     = 4'((s_data >> (4 * cur_slot)) & 32'hF);
        exp_fs  = (n % FRAME == 0);
        exp_an  = dark ? 8'hFF : ~(8'd1 << cur_slot);
        exp_seg = dark ? 8'hFF : {~s_dp[cur_slot], glyph[nib]};
        n++;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        data_bcd = 32'h7654_3210;
        #2 rst = 1'b1;
        #1;
        total++; if (an !== 8'hFF) begin bad++; $display("FAIL reset_an got=%h exp=ff", an); end
        total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", seg); end
        @(negedge clk); rst = 1'b0; n = 0;
        tick();
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL reset_fs got=%b exp=1", frame_start); end
        total++; if (an !== 8'hFF) begin bad++; $display("FAIL reset_blank got=%h exp=ff", an); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (an !== 8'hFE) begin bad++; $display("FAIL reset_slot0 i=%0d got=%h exp=fe", i, an); end
        end
        while (n < 14) tick();
        #2 rst = 1'b1;
        #1;
        total++; if (an !== 8'hFF || seg !== 8'hFF || frame_start !== 1'b0) begin
            bad++; $display("FAIL reset_mid an=%h seg=%h fs=%b exp=ff/ff/0", an, seg, frame_start);
        end
        @(negedge clk); rst = 1'b0; n = 0;
        tick();
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL reset_restart got=%b exp=1", frame_start); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (an !== 8'hFE) begin bad++; $display("FAIL reset_restart_an got=%h exp=fe", an); end
        end
    endtask

    task automatic test_scan();
        logic [7:0] segs [8];
        segs = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        data_bcd = 32'h7654_3210; dp_mask = 8'h00; blink_mask = 8'h00; lzb = 1'b0;
        do_reset();
        for (int i = 0; i < FRAME; i++) begin
            tick();
            total++; if (an !== exp_an || seg !== exp_seg || frame_start !== exp_fs) begin
                bad++; $display("FAIL scan_model n=%0d got=%h/%h/%b exp=%h/%h/%b", n-1, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if (cur_w == 2) begin
                total++; if (seg !== segs[cur_slot] || an !== ~(8'd1 << cur_slot)) begin
                    bad++; $display("FAIL scan_const slot=%0d got=%h/%h exp=%h", cur_slot, an, seg, segs[cur_slot]);
                end
            end
        end
    endtask

    task automatic test_coherence();
        logic [7:0] want;
        data_bcd = 32'h1111_1111; dp_mask = 8'h00; blink_mask = 8'h00; lzb = 1'b0;
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (n == 14) data_bcd = 32'h8888_8888;
            want = (n <= FRAME) ? 8'hF9 : 8'h80;
            if (cur_w != 0) begin
                total++; if (seg !== want) begin
                    bad++; $display("FAIL coherence n=%0d got=%h exp=%h", n-1, seg, want);
                end
            end
        end
    endtask

    task automatic test_lzb();
        logic [31:0] pats [3];
        logic [7:0]  lits [3];
        logic [7:0]  lit;
        pats = '{32'h0000_0120, 32'h0000_0000, 32'hA000_0000};
        lits = '{8'h07, 8'h01, 8'hFF};
        for (int p = 0; p < 3; p++) begin
            data_bcd = pats[p]; lzb = 1'b1; dp_mask = 8'h00; blink_mask = 8'h00;
            do_reset();
            lit = 8'h00;
            for (int i = 0; i < FRAME; i++) begin
                tick();
                if (an !== 8'hFF) lit = lit | ~an;
                total++; if (an !== exp_an || seg !== exp_seg) begin
                    bad++; $display("FAIL lzb_model p=%0d n=%0d got=%h/%h exp=%h/%h", p, n-1, an, seg, exp_an, exp_seg);
                end
            end
            total++; if (lit !== lits[p]) begin
                bad++; $display("FAIL lzb_lit p=%0d got=%h exp=%h", p, lit, lits[p]);
            end
        end
        lzb = 1'b0;
    endtask

    task automatic test_ac();
        data_bcd = 32'hAC05_0123; dp_mask = 8'h04; blink_mask = 8'h00; lzb = 1'b0;
        do_reset();
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (cur_w == 2) begin
                if (cur_slot == 7) begin
                    total++; if (seg !== 8'h88) begin bad++; $display("FAIL ac_d7 got=%h exp=88", seg); end
                end else if (cur_slot == 6) begin
                    total++; if (seg !== 8'hC6) begin bad++; $display("FAIL ac_d6 got=%h exp=c6", seg); end
                end else if (cur_slot == 2) begin
                    total++; if (seg !== 8'h79) begin bad++; $display("FAIL ac_d2 got=%h exp=79", seg); end
                end else begin
                    total++; if (seg[7] !== 1'b1) begin bad++; $display("FAIL ac_dp slot=%0d got=%b exp=1", cur_slot, seg[7]); end
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [5:0] lit0;
        data_bcd = $urandom; dp_mask = 8'h00; blink_mask = 8'h01; lzb = 1'b0;
        do_reset();
        lit0 = 6'b0;
        for (int i = 0; i < 6 * FRAME; i++) begin
            tick();
            if (an === 8'hFE) lit0[cur_fr] = 1'b1;
            total++; if (an !== exp_an || seg !== exp_seg) begin
                bad++; $display("FAIL blink_model n=%0d got=%h/%h exp=%h/%h", n-1, an, seg, exp_an, exp_seg);
            end
        end
        total++; if (lit0 !== 6'b110011) begin bad++; $display("FAIL blink_frames got=%b exp=110011", lit0); end
        blink_mask = 8'h00;
    endtask

    task automatic test_random();
        data_bcd = $urandom; dp_mask = 8'($urandom); blink_mask = 8'($urandom);
        lzb = 1'($urandom);
        do_reset();
        for (int i = 0; i < 20 * FRAME; i++) begin
            tick();
            total++; if (an !== exp_an || seg !== exp_seg || frame_start !== exp_fs) begin
                bad++; $display("FAIL random n=%0d got=%h/%h/%b exp=%h/%h/%b", n-1, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            if ($urandom_range(0, 15) == 0) begin
                data_bcd = ($urandom_range(0, 1) == 0) ? ($urandom >> (4 * $urandom_range(0, 7))) : $urandom;
                dp_mask = 8'($urandom); blink_mask = 8'($urandom); lzb = 1'($urandom);
            end
        end
    endtask

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        test_reset();
        test_scan();
        test_coherence();
        test_lzb();
        test_ac();
        test_blink();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
